// File: rtl/alu_share_if.sv
// Bundle of the two requester channels, the shared response bus and the ALU
// operand/result wires used by alu_share_arbiter.
interface alu_share_if #(
    parameter int N = 32
);
    logic         a_req_valid;
    logic         a_req_ready;
    logic [N-1:0] a_rs1;
    logic [N-1:0] a_rs2;
    logic [3:0]   a_alu_ctrl;
    logic         a_unsigned;
    logic         a_rsp_valid;
    logic         a_rsp_ready;

    logic         b_req_valid;
    logic         b_req_ready;
    logic [N-1:0] b_rs1;
    logic [N-1:0] b_rs2;
    logic [3:0]   b_alu_ctrl;
    logic         b_unsigned;
    logic         b_rsp_valid;
    logic         b_rsp_ready;

    logic [N-1:0] rsp_res;
    logic         rsp_zf;
    logic         rsp_neg;

    logic [N-1:0] alu_rs1;
    logic [N-1:0] alu_rs2;
    logic [3:0]   alu_ctrl;
    logic         alu_unsigned;
    logic [N-1:0] alu_res;
    logic         alu_zf;
    logic         alu_neg;

    logic         busy;
    logic         grant_b;

    modport slave (
        input  a_req_valid, a_rs1, a_rs2, a_alu_ctrl, a_unsigned, a_rsp_ready,
        input  b_req_valid, b_rs1, b_rs2, b_alu_ctrl, b_unsigned, b_rsp_ready,
        input  alu_res, alu_zf, alu_neg,
        output a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid,
        output rsp_res, rsp_zf, rsp_neg,
        output alu_rs1, alu_rs2, alu_ctrl, alu_unsigned,
        output busy, grant_b
    );

    modport master (
        output a_req_valid, a_rs1, a_rs2, a_alu_ctrl, a_unsigned, a_rsp_ready,
        output b_req_valid, b_rs1, b_rs2, b_alu_ctrl, b_unsigned, b_rsp_ready,
        output alu_res, alu_zf, alu_neg,
        input  a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid,
        input  rsp_res, rsp_zf, rsp_neg,
        input  alu_rs1, alu_rs2, alu_ctrl, alu_unsigned,
        input  busy, grant_b
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between requesters A and B, one op in flight.
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed A > B.
module alu_share_arbiter #(
    parameter int N = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_share_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t       state_reg, state_next;
    logic         take_a, take_b, pick_b;
    logic         grant_b_reg;
    logic [N-1:0] alu_rs1_reg, alu_rs2_reg, rsp_res_reg;
    logic [3:0]   alu_ctrl_reg;
    logic         alu_unsigned_reg, rsp_zf_reg, rsp_neg_reg;
    logic         owner_rsp_ready;

`ifdef ALU_ARB_RR_EN
    // 1 = B was served last, so A wins the first contended arbitration.
    logic last_grant_reg;
    assign pick_b = bus.b_req_valid & (~bus.a_req_valid | ~last_grant_reg);
`else
    assign pick_b = bus.b_req_valid & ~bus.a_req_valid;
`endif

    assign owner_rsp_ready = grant_b_reg ? bus.b_rsp_ready : bus.a_rsp_ready;

    always_comb begin
        state_next = state_reg;
        take_a     = 1'b0;
        take_b     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.a_req_valid | bus.b_req_valid) begin
                    take_b     = pick_b;
                    take_a     = ~pick_b;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = RESP;
            RESP: begin
                if (owner_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            grant_b_reg      <= 1'b0;
            alu_rs1_reg      <= '0;
            alu_rs2_reg      <= '0;
            alu_ctrl_reg     <= '0;
            alu_unsigned_reg <= 1'b0;
            rsp_res_reg      <= '0;
            rsp_zf_reg       <= 1'b0;
            rsp_neg_reg      <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_grant_reg   <= 1'b1;
`endif
        end else begin
            state_reg <= state_next;
            if (take_a | take_b) begin
                grant_b_reg      <= take_b;
                alu_rs1_reg      <= take_b ? bus.b_rs1      : bus.a_rs1;
                alu_rs2_reg      <= take_b ? bus.b_rs2      : bus.a_rs2;
                alu_ctrl_reg     <= take_b ? bus.b_alu_ctrl : bus.a_alu_ctrl;
                alu_unsigned_reg <= take_b ? bus.b_unsigned : bus.a_unsigned;
            end
            if (state_reg == ISSUE) begin
                rsp_res_reg <= bus.alu_res;
                rsp_zf_reg  <= bus.alu_zf;
                rsp_neg_reg <= bus.alu_neg;
            end
`ifdef ALU_ARB_RR_EN
            if (state_reg == RESP && owner_rsp_ready) begin
                last_grant_reg <= grant_b_reg;
            end
`endif
        end
    end

    // Ready is combinational on valid; gated so every output reads 0 in reset.
    assign bus.a_req_ready  = take_a & rst_n;
    assign bus.b_req_ready  = take_b & rst_n;
    assign bus.a_rsp_valid  = (state_reg == RESP) & ~grant_b_reg;
    assign bus.b_rsp_valid  = (state_reg == RESP) &  grant_b_reg;
    assign bus.busy         = (state_reg != IDLE);
    assign bus.grant_b      = grant_b_reg;
    assign bus.rsp_res      = rsp_res_reg;
    assign bus.rsp_zf       = rsp_zf_reg;
    assign bus.rsp_neg      = rsp_neg_reg;
    assign bus.alu_rs1      = alu_rs1_reg;
    assign bus.alu_rs2      = alu_rs2_reg;
    assign bus.alu_ctrl     = alu_ctrl_reg;
    assign bus.alu_unsigned = alu_unsigned_reg;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus a random
// run checked against a transaction-level model of the arbiter.
module tb_alu_share_arbiter;
    localparam int N = 32;
`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    alu_share_if #(.N(N)) bus ();

    alu_share_arbiter #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference ALU: undefined opcodes return 0.
    function automatic logic [N-1:0] alu_ref(input logic [3:0] ctrl, input logic [N-1:0] x,
                                             input logic [N-1:0] y, input logic uns);
        logic [N-1:0] r;
        case (ctrl)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: r = x + y;
            4'b0110: r = x - y;
            4'b0111: r = uns ? {{(N-1){1'b0}}, (x < y)} : {{(N-1){1'b0}}, ($signed(x) < $signed(y))};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        bus.alu_res = alu_ref(bus.alu_ctrl, bus.alu_rs1, bus.alu_rs2, bus.alu_unsigned);
        bus.alu_zf  = (bus.alu_res == '0);
        bus.alu_neg = bus.alu_res[N-1];
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.a_req_valid = 0; bus.a_rs1 = '0; bus.a_rs2 = '0; bus.a_alu_ctrl = '0;
        bus.a_unsigned = 0; bus.a_rsp_ready = 0;
        bus.b_req_valid = 0; bus.b_rs1 = '0; bus.b_rs2 = '0; bus.b_alu_ctrl = '0;
        bus.b_unsigned = 0; bus.b_rsp_ready = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        bus.a_req_valid = 1'b1;
        bus.b_req_valid = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (bus.a_req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_a_req_ready got %b want 0", bus.a_req_ready); end
        n_cmp++; if (bus.b_req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_b_req_ready got %b want 0", bus.b_req_ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if ({bus.a_rsp_valid, bus.b_rsp_valid, bus.grant_b} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {bus.a_rsp_valid, bus.b_rsp_valid, bus.grant_b}); end
        n_cmp++; if ({bus.rsp_res, bus.alu_rs1, bus.alu_rs2} !== '0) begin n_bad++; $display("FAIL reset_regs got %h/%h/%h want 0", bus.rsp_res, bus.alu_rs1, bus.alu_rs2); end
        clear_inputs();
        rst_n = 1'b1;
        tick();
        $display("txn reset done");
    endtask

    task automatic test_a_only();
        bus.a_req_valid = 1; bus.a_rs1 = 5; bus.a_rs2 = 7; bus.a_alu_ctrl = 4'b0010;
        bus.a_rsp_ready = 1; bus.b_rsp_ready = 1;
        #1;
        n_cmp++; if (bus.a_req_ready !== 1'b1) begin n_bad++; $display("FAIL a_only_ready got %b want 1", bus.a_req_ready); end
        n_cmp++; if (bus.b_req_ready !== 1'b0) begin n_bad++; $display("FAIL a_only_b_ready got %b want 0", bus.b_req_ready); end
        tick();
        bus.a_req_valid = 0;
        #1;
        n_cmp++; if ({bus.busy, bus.a_req_ready, bus.a_rsp_valid} !== 3'b100) begin n_bad++; $display("FAIL a_only_issue got %b want 100", {bus.busy, bus.a_req_ready, bus.a_rsp_valid}); end
        tick();
        #1;
        n_cmp++; if ({bus.a_rsp_valid, bus.b_rsp_valid, bus.grant_b} !== 3'b100) begin n_bad++; $display("FAIL a_only_rsp_flags got %b want 100", {bus.a_rsp_valid, bus.b_rsp_valid, bus.grant_b}); end
        n_cmp++; if ({bus.rsp_res, bus.rsp_zf, bus.rsp_neg} !== {32'd12, 2'b00}) begin n_bad++; $display("FAIL a_only_res got %h zf=%b neg=%b want 12/0/0", bus.rsp_res, bus.rsp_zf, bus.rsp_neg); end
        tick();
        #1;
        n_cmp++; if ({bus.busy, bus.a_rsp_valid} !== 2'b00) begin n_bad++; $display("FAIL a_only_done got %b want 00", {bus.busy, bus.a_rsp_valid}); end
        tick();
        $display("txn A 5+7 -> %0d", bus.rsp_res);
    endtask

    task automatic test_b_only();
        bus.b_req_valid = 1; bus.b_rs1 = 3; bus.b_rs2 = 3; bus.b_alu_ctrl = 4'b0110;
        #1;
        n_cmp++; if ({bus.a_req_ready, bus.b_req_ready} !== 2'b01) begin n_bad++; $display("FAIL b_only_ready got %b want 01", {bus.a_req_ready, bus.b_req_ready}); end
        tick();
        bus.b_req_valid = 0;
        #1;
        n_cmp++; if (bus.grant_b !== 1'b1) begin n_bad++; $display("FAIL b_only_grant got %b want 1", bus.grant_b); end
        tick();
        #1;
        n_cmp++; if ({bus.a_rsp_valid, bus.b_rsp_valid} !== 2'b01) begin n_bad++; $display("FAIL b_only_rsp_valid got %b want 01", {bus.a_rsp_valid, bus.b_rsp_valid}); end
        n_cmp++; if ({bus.rsp_res, bus.rsp_zf, bus.rsp_neg} !== {32'd0, 2'b10}) begin n_bad++; $display("FAIL b_only_res got %h zf=%b neg=%b want 0/1/0", bus.rsp_res, bus.rsp_zf, bus.rsp_neg); end
        tick();
        $display("txn B 3-3 -> %0d", bus.rsp_res);
    endtask

    task automatic test_contention();
        int acc_n = 0;
        bit owners[8];
        bus.a_req_valid = 1; bus.a_rs1 = 1; bus.a_rs2 = 1; bus.a_alu_ctrl = 4'b0010;
        bus.b_req_valid = 1; bus.b_rs1 = 0; bus.b_rs2 = 1; bus.b_alu_ctrl = 4'b0110;
        bus.a_rsp_ready = 1; bus.b_rsp_ready = 1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bus.a_req_ready && acc_n < 8) begin owners[acc_n] = 1'b0; acc_n++; end
            if (bus.b_req_ready && acc_n < 8) begin owners[acc_n] = 1'b1; acc_n++; end
`ifndef ALU_ARB_RR_EN
            n_cmp++; if (bus.b_req_ready !== 1'b0) begin n_bad++; $display("FAIL fixed_b_starved got %b want 0 cycle %0d", bus.b_req_ready, c); end
`endif
            if (bus.a_rsp_valid) begin
                n_cmp++; if ({bus.rsp_res, bus.rsp_zf, bus.rsp_neg} !== {32'd2, 2'b00}) begin n_bad++; $display("FAIL cont_a_res got %h zf=%b neg=%b want 2/0/0", bus.rsp_res, bus.rsp_zf, bus.rsp_neg); end
                $display("txn A 1+1 -> %h", bus.rsp_res);
            end
            if (bus.b_rsp_valid) begin
                n_cmp++; if ({bus.rsp_res, bus.rsp_zf, bus.rsp_neg} !== {32'hFFFF_FFFF, 2'b01}) begin n_bad++; $display("FAIL cont_b_res got %h zf=%b neg=%b want ffffffff/0/1", bus.rsp_res, bus.rsp_zf, bus.rsp_neg); end
                $display("txn B 0-1 -> %h", bus.rsp_res);
            end
            tick();
        end
        clear_inputs();
        n_cmp++; if (acc_n !== 4) begin n_bad++; $display("FAIL cont_accept_count got %0d want 4", acc_n); end
        for (int i = 0; i < acc_n && i < 4; i++) begin
            n_cmp++;
            if (owners[i] !== (RR ? (i % 2 == 1) : 1'b0)) begin
                n_bad++; $display("FAIL cont_order[%0d] got %b want %b", i, owners[i], (RR ? (i % 2 == 1) : 1'b0));
            end
        end
    endtask

    task automatic test_backpressure();
        bus.a_req_valid = 1; bus.a_rs1 = 10; bus.a_rs2 = 20; bus.a_alu_ctrl = 4'b0010;
        bus.a_rsp_ready = 0; bus.b_rsp_ready = 1;
        #1;
        n_cmp++; if (bus.a_req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_accept got %b want 1", bus.a_req_ready); end
        tick();
        bus.a_rs1 = 55; bus.a_rs2 = 1; bus.b_req_valid = 1; bus.b_rs1 = 77;
        tick();
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++; if ({bus.a_rsp_valid, bus.busy, bus.a_req_ready, bus.b_req_ready} !== 4'b1100) begin n_bad++; $display("FAIL bp_hold_flags got %b want 1100 cycle %0d", {bus.a_rsp_valid, bus.busy, bus.a_req_ready, bus.b_req_ready}, c); end
            n_cmp++; if ({bus.rsp_res, bus.alu_rs1} !== {32'd30, 32'd10}) begin n_bad++; $display("FAIL bp_hold_regs got res=%0d alu_rs1=%0d want 30/10", bus.rsp_res, bus.alu_rs1); end
            tick();
        end
        bus.b_req_valid = 0;
        bus.a_rsp_ready = 1;
        #1;
        n_cmp++; if (bus.a_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_release_valid got %b want 1", bus.a_rsp_valid); end
        $display("txn A 10+20 -> %0d", bus.rsp_res);
        tick();
        #1;
        n_cmp++; if ({bus.busy, bus.a_rsp_valid, bus.a_req_ready} !== 3'b001) begin n_bad++; $display("FAIL bp_next_accept got %b want 001", {bus.busy, bus.a_rsp_valid, bus.a_req_ready}); end
        tick();
        bus.a_req_valid = 0;
        tick();
        #1;
        n_cmp++; if ({bus.a_rsp_valid, bus.rsp_res} !== {1'b1, 32'd56}) begin n_bad++; $display("FAIL bp_next_res got v=%b res=%0d want 1/56", bus.a_rsp_valid, bus.rsp_res); end
        $display("txn A 55+1 -> %0d", bus.rsp_res);
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid_op();
        bus.a_req_valid = 1; bus.a_rs1 = 9; bus.a_rs2 = 9; bus.a_alu_ctrl = 4'b0010; bus.a_rsp_ready = 1;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.busy, bus.a_req_ready, bus.a_rsp_valid, bus.grant_b} !== 4'b0000) begin n_bad++; $display("FAIL midrst_flags got %b want 0000", {bus.busy, bus.a_req_ready, bus.a_rsp_valid, bus.grant_b}); end
        n_cmp++; if ({bus.alu_rs1, bus.alu_ctrl, bus.rsp_res} !== '0) begin n_bad++; $display("FAIL midrst_regs got %h/%h/%h want 0", bus.alu_rs1, bus.alu_ctrl, bus.rsp_res); end
        tick();
        rst_n = 1'b1;
        bus.a_req_valid = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++; if ({bus.a_rsp_valid, bus.busy} !== 2'b00) begin n_bad++; $display("FAIL midrst_no_rsp got %b want 00 cycle %0d", {bus.a_rsp_valid, bus.busy}, c); end
            tick();
        end
        bus.a_req_valid = 1; bus.a_rs1 = 100; bus.a_rs2 = 1; bus.a_alu_ctrl = 4'b0110;
        #1;
        n_cmp++; if (bus.a_req_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_accept got %b want 1", bus.a_req_ready); end
        tick();
        bus.a_req_valid = 0;
        tick();
        #1;
        n_cmp++; if ({bus.a_rsp_valid, bus.rsp_res} !== {1'b1, 32'd99}) begin n_bad++; $display("FAIL midrst_res got v=%b res=%0d want 1/99", bus.a_rsp_valid, bus.rsp_res); end
        $display("txn A 100-1 -> %0d", bus.rsp_res);
        tick();
        clear_inputs();
    endtask

    // Transaction-level model: one op outstanding; response visible two cycles
    // after acceptance and held until its owner consumes it.
    task automatic test_random();
        bit pend = 0, own_b = 0, last_b = 1, exp_ar, exp_br, own_rdy;
        int age = 0;
        logic [N-1:0] e_rs1 = '0, e_rs2 = '0, e_res;
        logic [3:0] e_ctrl = '0;
        bit e_uns = 0;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.a_req_valid = ($urandom_range(0, 99) < 60);
            bus.a_rs1 = $urandom; bus.a_rs2 = $urandom;
            bus.a_alu_ctrl = 4'($urandom_range(0, 15)); bus.a_unsigned = 1'($urandom_range(0, 1));
            bus.a_rsp_ready = ($urandom_range(0, 99) < 50);
            bus.b_req_valid = ($urandom_range(0, 99) < 60);
            bus.b_rs1 = $urandom; bus.b_rs2 = $urandom;
            bus.b_alu_ctrl = 4'($urandom_range(0, 15)); bus.b_unsigned = 1'($urandom_range(0, 1));
            bus.b_rsp_ready = ($urandom_range(0, 99) < 50);
            #1;
            exp_ar = !pend && bus.a_req_valid && (RR ? (!bus.b_req_valid || last_b) : 1'b1);
            exp_br = !pend && bus.b_req_valid && !exp_ar;
            e_res  = alu_ref(e_ctrl, e_rs1, e_rs2, e_uns);
            n_cmp++; if ({bus.a_req_ready, bus.b_req_ready, bus.busy} !== {exp_ar, exp_br, pend}) begin n_bad++; $display("FAIL rnd_ready_busy got %b want %b cycle %0d", {bus.a_req_ready, bus.b_req_ready, bus.busy}, {exp_ar, exp_br, pend}, cyc); end
            n_cmp++; if ({bus.a_rsp_valid, bus.b_rsp_valid} !== {pend && age >= 2 && !own_b, pend && age >= 2 && own_b}) begin n_bad++; $display("FAIL rnd_rsp_valid got %b want %b cycle %0d", {bus.a_rsp_valid, bus.b_rsp_valid}, {pend && age >= 2 && !own_b, pend && age >= 2 && own_b}, cyc); end
            n_cmp++; if ({bus.alu_rs1, bus.alu_rs2, bus.alu_ctrl, bus.alu_unsigned} !== {e_rs1, e_rs2, e_ctrl, e_uns}) begin n_bad++; $display("FAIL rnd_alu_regs got %h %h %h %b want %h %h %h %b cycle %0d", bus.alu_rs1, bus.alu_rs2, bus.alu_ctrl, bus.alu_unsigned, e_rs1, e_rs2, e_ctrl, e_uns, cyc); end
            if (pend && age >= 2) begin
                n_cmp++; if ({bus.rsp_res, bus.rsp_zf, bus.rsp_neg, bus.grant_b} !== {e_res, e_res == '0, e_res[N-1], own_b}) begin n_bad++; $display("FAIL rnd_rsp got %h %b %b g=%b want %h %b %b g=%b cycle %0d", bus.rsp_res, bus.rsp_zf, bus.rsp_neg, bus.grant_b, e_res, e_res == '0, e_res[N-1], own_b, cyc); end
            end
            own_rdy = own_b ? bus.b_rsp_ready : bus.a_rsp_ready;
            if (pend) begin
                if (age >= 2 && own_rdy) begin
                    pend = 0;
                    last_b = own_b;
                    $display("txn %s ctrl=%h rs1=%h rs2=%h -> %h", own_b ? "B" : "A", e_ctrl, e_rs1, e_rs2, e_res);
                end else if (age < 2) begin
                    age++;
                end
            end else if (exp_ar || exp_br) begin
                pend   = 1;
                own_b  = exp_br;
                age    = 1;
                e_rs1  = exp_br ? bus.b_rs1 : bus.a_rs1;
                e_rs2  = exp_br ? bus.b_rs2 : bus.a_rs2;
                e_ctrl = exp_br ? bus.b_alu_ctrl : bus.a_alu_ctrl;
                e_uns  = exp_br ? bus.b_unsigned : bus.a_unsigned;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_a_only();
        test_b_only();
        test_contention();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
